// File: rtl/ahb_master_datapath.sv
// AHB-Lite master address/data-phase engine driven by a one-hot control state.
// Issues SINGLE and INCR transfers, pipelines data phases and handles error aborts.
module ahb_master_datapath #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEAT_W = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [5:0]        STATE,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] WDATA_IN,
    input  logic [2:0]        SIZE_IN,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] RDATA_OUT,
    output logic              RDATA_VALID,
    output logic              ERR,
    output logic [BEAT_W-1:0] BEAT_CNT
);

    localparam logic [5:0] ST_IDLE    = 6'b000001;
    localparam logic [5:0] ST_SBURSTW = 6'b000010;
    localparam logic [5:0] ST_SBURSTR = 6'b000100;
    localparam logic [5:0] ST_INCRBW  = 6'b001000;
    localparam logic [5:0] ST_INCRBR  = 6'b010000;
    localparam logic [5:0] ST_BUSY    = 6'b100000;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;

    localparam logic [BEAT_W-1:0] BEAT_MAX = {BEAT_W{1'b1}};
    localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_haddr;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [2:0]        r_hburst;
    logic [DATA_W-1:0] r_hwdata;
    logic [DATA_W-1:0] r_wdata_hold;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_err;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_dp_active;
    logic              r_dp_write;
    logic              r_dp_err;
    logic              r_burst_live;
    logic              r_burst_dir;
    logic              r_busy_hold;

    logic [ADDR_W-1:0] w_inc_addr;
    logic [ADDR_W-1:0] w_cont_addr;
    logic              w_incr_dir;
    logic              w_err_det;
    logic              w_rd_done;
    logic [ADDR_W-1:0] w_n_haddr;
    logic [1:0]        w_n_htrans;
    logic              w_n_hwrite;
    logic [2:0]        w_n_hsize;
    logic [2:0]        w_n_hburst;
    logic [BEAT_W-1:0] w_n_beat_cnt;
    logic              w_n_burst_live;
    logic              w_n_burst_dir;
    logic              w_n_busy_hold;

    // Next address-phase selection from the control state.
    always_comb begin
        w_inc_addr     = r_haddr + (ADDR_ONE << r_hsize);
        w_cont_addr    = r_busy_hold ? r_haddr : w_inc_addr;
        w_incr_dir     = (STATE == ST_INCRBW) ? 1'b1 : 1'b0;
        w_err_det      = HRESP & ~HREADY & r_dp_active & ~r_dp_err;
        w_rd_done      = HREADY & r_dp_active & ~r_dp_write & ~r_dp_err;
        w_n_haddr      = r_haddr;
        w_n_htrans     = TR_IDLE;
        w_n_hwrite     = r_hwrite;
        w_n_hsize      = r_hsize;
        w_n_hburst     = BU_SINGLE;
        w_n_beat_cnt   = r_beat_cnt;
        w_n_burst_live = 1'b0;
        w_n_burst_dir  = r_burst_dir;
        w_n_busy_hold  = 1'b0;
        case (STATE)
            ST_SBURSTW, ST_SBURSTR: begin
                w_n_htrans   = TR_NONSEQ;
                w_n_haddr    = ADDR_IN;
                w_n_hwrite   = (STATE == ST_SBURSTW) ? 1'b1 : 1'b0;
                w_n_hsize    = SIZE_IN;
                w_n_beat_cnt = {BEAT_W{1'b0}};
            end
            ST_INCRBW, ST_INCRBR: begin
                w_n_hburst     = BU_INCR;
                w_n_burst_live = 1'b1;
                w_n_burst_dir  = w_incr_dir;
                if (r_burst_live && (r_burst_dir == w_incr_dir)) begin
                    // A continuation landing on a 1 KB boundary must restart as NONSEQ.
                    w_n_haddr    = w_cont_addr;
                    w_n_htrans   = (w_cont_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                    w_n_beat_cnt = (r_beat_cnt == BEAT_MAX) ? BEAT_MAX : r_beat_cnt + BEAT_ONE;
                end else begin
                    w_n_haddr    = ADDR_IN;
                    w_n_htrans   = TR_NONSEQ;
                    w_n_hwrite   = w_incr_dir;
                    w_n_hsize    = SIZE_IN;
                    w_n_beat_cnt = BEAT_ONE;
                end
            end
            ST_BUSY: begin
                if (r_burst_live) begin
                    w_n_htrans     = TR_BUSY;
                    w_n_haddr      = w_cont_addr;
                    w_n_hburst     = BU_INCR;
                    w_n_burst_live = 1'b1;
                    w_n_busy_hold  = 1'b1;
                end else begin
                    w_n_htrans = TR_IDLE;
                end
            end
            default: begin
                w_n_htrans = TR_IDLE;
            end
        endcase
    end

    // Address-phase, data-phase and status registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_haddr      <= {ADDR_W{1'b0}};
            r_htrans     <= TR_IDLE;
            r_hwrite     <= 1'b0;
            r_hsize      <= 3'b010;
            r_hburst     <= BU_SINGLE;
            r_hwdata     <= {DATA_W{1'b0}};
            r_wdata_hold <= {DATA_W{1'b0}};
            r_rdata      <= {DATA_W{1'b0}};
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_beat_cnt   <= {BEAT_W{1'b0}};
            r_dp_active  <= 1'b0;
            r_dp_write   <= 1'b0;
            r_dp_err     <= 1'b0;
            r_burst_live <= 1'b0;
            r_burst_dir  <= 1'b0;
            r_busy_hold  <= 1'b0;
        end else begin
            r_err    <= w_err_det;
            r_rvalid <= w_rd_done;
            if (w_rd_done) begin
                r_rdata <= HRDATA;
            end
            if (w_err_det) begin
                // Cancel the pending address phase and break the burst.
                r_htrans     <= TR_IDLE;
                r_burst_live <= 1'b0;
                r_busy_hold  <= 1'b0;
                r_dp_err     <= 1'b1;
            end else if (HREADY) begin
                r_haddr      <= w_n_haddr;
                r_htrans     <= w_n_htrans;
                r_hwrite     <= w_n_hwrite;
                r_hsize      <= w_n_hsize;
                r_hburst     <= w_n_hburst;
                r_beat_cnt   <= w_n_beat_cnt;
                r_burst_live <= w_n_burst_live;
                r_burst_dir  <= w_n_burst_dir;
                r_busy_hold  <= w_n_busy_hold;
                r_dp_active  <= r_htrans[1];
                r_dp_write   <= r_hwrite;
                r_dp_err     <= 1'b0;
                if (w_n_htrans[1] && w_n_hwrite) begin
                    r_wdata_hold <= WDATA_IN;
                end
                if (r_htrans[1] && r_hwrite) begin
                    r_hwdata <= r_wdata_hold;
                end
            end
        end
    end

    assign HADDR       = r_haddr;
    assign HTRANS      = r_htrans;
    assign HWRITE      = r_hwrite;
    assign HSIZE       = r_hsize;
    assign HBURST      = r_hburst;
    assign HWDATA      = r_hwdata;
    assign RDATA_OUT   = r_rdata;
    assign RDATA_VALID = r_rvalid;
    assign ERR         = r_err;
    assign BEAT_CNT    = r_beat_cnt;

endmodule

// File: doc/ahb_master_datapath.md
Name: ahb_master_datapath

Overview:
Address/data-phase engine that consumes the one-hot STATE vector produced by the AHB master control FSM. It drives the AHB-Lite master bus signals: HADDR, HTRANS, HWRITE, HSIZE, HBURST and HWDATA. It also returns read data and error status to the MIPS-side requester. Pipelining follows the AHB model: each address phase is followed by its data phase, and both are extended by HREADY low.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data bus width
BEAT_W, 8, width of the INCR beat counter (saturates at all-ones)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
STATE  in  6  one-hot control state: IDLE=000001, SBURSTW=000010, SBURSTR=000100, INCRBW=001000, INCRBR=010000, BUSY=100000
ADDR_IN  in  ADDR_W  start address for NONSEQ beats
WDATA_IN  in  DATA_W  write data, sampled together with each write address phase
SIZE_IN  in  3  transfer size (0=byte, 1=half, 2=word)
HREADY  in  1  slave ready
HRESP  in  1  slave error response
HRDATA  in  DATA_W  slave read data
HADDR  out  ADDR_W  bus address
HTRANS  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  out  1  direction
HSIZE  out  3  size
HBURST  out  3  000 SINGLE, 001 INCR
HWDATA  out  DATA_W  write data (data phase)
RDATA_OUT  out  DATA_W  captured read data
RDATA_VALID  out  1  one-cycle pulse per completed read beat
ERR  out  1  one-cycle pulse on error response
BEAT_CNT  out  BEAT_W  accepted beats in the current INCR burst

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESETn is asynchronous and active-low.
- Reset values: HADDR=0, HTRANS=00, HWRITE=0, HSIZE=010, HBURST=000, HWDATA=0, RDATA_OUT=0, RDATA_VALID=0, ERR=0, BEAT_CNT=0, and all internal pipeline registers cleared.
- Reset mid-transfer: abandons the transfer with no completion pulse.
- Address-phase outputs: registered. They update only on a HCLK edge where HREADY=1; otherwise they hold. The only exception is the error override below.
- Next address phase, selected from STATE at each HREADY=1 edge:
  - IDLE: HTRANS=IDLE, HBURST=SINGLE. HADDR, HWRITE and HSIZE hold.
  - SBURSTW / SBURSTR: HTRANS=NONSEQ, HADDR=ADDR_IN, HWRITE=1/0, HSIZE=SIZE_IN, HBURST=SINGLE. BEAT_CNT=0.
  - INCRBW / INCRBR, first beat: HTRANS=NONSEQ, HADDR=ADDR_IN, HBURST=INCR, BEAT_CNT=1. A beat is a first beat when the previous issued address phase was not an INCR beat in the same direction and not BUSY within the same burst.
  - INCRBW / INCRBR, continuation: HTRANS=SEQ, HADDR = previous HADDR + (1<<HSIZE). HSIZE and HWRITE hold. BEAT_CNT increments and saturates.
  - 1 KB boundary: if the incremented address has addr[9:0]==0, issue NONSEQ instead of SEQ, using the incremented address.
  - BUSY, entered from an INCR beat: HTRANS=BUSY, HADDR = next-beat address (precomputed), HBURST=INCR. On return to the same INCR state, the next beat is SEQ at that held address.
  - BUSY, entered otherwise: HTRANS=IDLE.
- Data phase starts at the HREADY=1 edge that accepts a NONSEQ or SEQ address phase. It records dir=HWRITE and an active flag. IDLE/BUSY address phases create no data phase.
- Write data:
  - WDATA_IN is captured into a hold register at the same edge that issues the write address.
  - At the acceptance edge, the hold register moves to HWDATA.
  - HWDATA holds while HREADY=0.
- Read data: at an HREADY=1 edge ending an active read data phase, RDATA_OUT<=HRDATA and RDATA_VALID=1 for one cycle.
- Back-to-back pipelining: the data phase of beat N overlaps the address phase of beat N+1. Sustained throughput is 1 beat/cycle while HREADY=1.
- Error response:
  - First error cycle: HRESP=1 with HREADY=0 during an active data phase.
  - On the following edge, HTRANS is forced to IDLE regardless of HREADY.
  - ERR pulses for exactly one cycle.
  - The burst is marked broken, so the next INCR beat restarts with NONSEQ at ADDR_IN and BEAT_CNT=1.
  - The errored read produces no RDATA_VALID.
- Invalid STATE (not one-hot): treated as IDLE.

Test Plan:
1. Reset, then STATE=SBURSTW, ADDR_IN=0x100, WDATA_IN=0xA5A5A5A5, HREADY=1 -> next edge HTRANS=10, HADDR=0x100, HWRITE=1, HBURST=000; following edge HWDATA=0xA5A5A5A5.
2. STATE=INCRBR for 4 cycles, ADDR_IN=0x200, SIZE=2, HRDATA=beat index -> HADDR 0x200/204/208/20C, HTRANS 10,11,11,11, BEAT_CNT 1..4; four RDATA_VALID pulses with RDATA_OUT 0..3, each one cycle after its address.
3. INCRBW at 0x3F8, size 2, 3 beats -> addresses 0x3F8 (NONSEQ), 0x3FC (SEQ), 0x400 (NONSEQ, boundary).
4. INCRBR beat at 0x500, then STATE=BUSY for 2 cycles, then INCRBR -> HTRANS=01 with HADDR=0x504 for 2 cycles, then SEQ at 0x504.
5. HREADY low for 3 cycles during a write data phase -> HADDR, HTRANS and HWDATA stable throughout; advance occurs on the first HREADY=1 edge.
6. Read data phase with HRESP=1, HREADY=0 -> next edge HTRANS=00, ERR one-cycle pulse, no RDATA_VALID; next INCRBR beat issues NONSEQ at ADDR_IN with BEAT_CNT=1.
